// File: rtl/rgb_spi_pkg.sv
// Shared constants, state type and helpers for the RGB SPI command receiver.
// Command bytes, per-command data lengths and the fade step function.
package rgb_spi_pkg;

  localparam logic [7:0] CMD_SET    = 8'h01;
  localparam logic [7:0] CMD_FADE   = 8'h02;
  localparam logic [7:0] CMD_ENABLE = 8'h03;

  localparam int unsigned SET_BYTES    = 3;
  localparam int unsigned FADE_BYTES   = 3;
  localparam int unsigned ENABLE_BYTES = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DISCARD
  } rx_state_e;

  function automatic logic cmd_valid(input logic [7:0] c);
    return (c == CMD_SET) || (c == CMD_FADE) || (c == CMD_ENABLE);
  endfunction

  function automatic logic [1:0] last_idx(input logic [7:0] c);
    logic [1:0] n;
    n = 2'(SET_BYTES - 1);
    if (c == CMD_FADE)   n = 2'(FADE_BYTES - 1);
    if (c == CMD_ENABLE) n = 2'(ENABLE_BYTES - 1);
    return n;
  endfunction

  function automatic logic [7:0] step_toward(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    logic [7:0] n;
    n = cur;
    if (cur < tgt) n = cur + 8'd1;
    if (cur > tgt) n = cur - 8'd1;
    return n;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin with edge detect.
// RST_VAL is the pin's idle level so no edge is seen leaving reset.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/rgb_spi_rx.sv
// SPI-slave command receiver feeding the RGB delta-sigma drivers.
// Decodes SET/FADE/ENABLE frames and runs the per-channel fade engine.
module rgb_spi_rx
  import rgb_spi_pkg::*;
#(
  parameter int unsigned FADE_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic [7:0] led_r_out,
  output logic [7:0] led_g_out,
  output logic [7:0] led_b_out,
  output logic       enable_out,
  output logic       frame_done
);

  localparam logic [15:0] PRESC_MAX = 16'(FADE_DIV - 1);

  logic sck_rise, sck_s, sck_fall_unused;
  logic cs_s, cs_rise_unused, cs_fall_unused;
  logic mosi_meta_q, mosi_q;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_sck),
    .sync (sck_s),
    .rise (sck_rise),
    .fall (sck_fall_unused)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs_n),
    .sync (cs_s),
    .rise (cs_rise_unused),
    .fall (cs_fall_unused)
  );

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  sh_r_q, sh_r_d;
  logic [7:0]  sh_g_q, sh_g_d;
  logic [7:0]  cur_r_q, cur_r_d;
  logic [7:0]  cur_g_q, cur_g_d;
  logic [7:0]  cur_b_q, cur_b_d;
  logic [7:0]  tgt_r_q, tgt_r_d;
  logic [7:0]  tgt_g_q, tgt_g_d;
  logic [7:0]  tgt_b_q, tgt_b_d;
  logic        en_q, en_d;
  logic        done_q, done_d;
  logic [15:0] presc_q, presc_d;
  logic        tick;
  logic        byte_end;
  logic [7:0]  byte_in;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    sh_r_d     = sh_r_q;
    sh_g_d     = sh_g_q;
    cur_r_d    = cur_r_q;
    cur_g_d    = cur_g_q;
    cur_b_d    = cur_b_q;
    tgt_r_d    = tgt_r_q;
    tgt_g_d    = tgt_g_q;
    tgt_b_d    = tgt_b_q;
    en_d       = en_q;
    done_d     = 1'b0;

    tick     = (presc_q == PRESC_MAX);
    presc_d  = tick ? 16'd0 : presc_q + 16'd1;
    byte_in  = {shift_q[6:0], mosi_q};
    byte_end = sck_rise && (bit_cnt_q == 3'd7);

    // Fade step first so a SET commit below overrides it.
    if (tick) begin
      cur_r_d = step_toward(cur_r_q, tgt_r_q);
      cur_g_d = step_toward(cur_g_q, tgt_g_q);
      cur_b_d = step_toward(cur_b_q, tgt_b_q);
    end

    if (cs_s) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 2'd0;
      shift_d    = 8'd0;
      sh_r_d     = 8'd0;
      sh_g_d     = 8'd0;
    end else begin
      if (sck_rise && (state_q inside {ST_CMD, ST_DATA})) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (byte_end) begin
            cmd_d      = byte_in;
            byte_idx_d = 2'd0;
            state_d    = cmd_valid(byte_in) ? ST_DATA : ST_DISCARD;
          end
        end
        ST_DATA: begin
          if (byte_end && (byte_idx_q == last_idx(cmd_q))) begin
            state_d = ST_DISCARD;
            done_d  = 1'b1;
            if (cmd_q == CMD_ENABLE) begin
              en_d = byte_in[0];
            end else begin
              tgt_r_d = sh_r_q;
              tgt_g_d = sh_g_q;
              tgt_b_d = byte_in;
              if (cmd_q == CMD_SET) begin
                cur_r_d = sh_r_q;
                cur_g_d = sh_g_q;
                cur_b_d = byte_in;
              end
            end
          end else if (byte_end) begin
            if (byte_idx_q == 2'd0) sh_r_d = byte_in;
            else                    sh_g_d = byte_in;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      cmd_q       <= 8'd0;
      shift_q     <= 8'd0;
      sh_r_q      <= 8'd0;
      sh_g_q      <= 8'd0;
      cur_r_q     <= 8'd0;
      cur_g_q     <= 8'd0;
      cur_b_q     <= 8'd0;
      tgt_r_q     <= 8'd0;
      tgt_g_q     <= 8'd0;
      tgt_b_q     <= 8'd0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      presc_q     <= 16'd0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_q      <= mosi_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      sh_r_q      <= sh_r_d;
      sh_g_q      <= sh_g_d;
      cur_r_q     <= cur_r_d;
      cur_g_q     <= cur_g_d;
      cur_b_q     <= cur_b_d;
      tgt_r_q     <= tgt_r_d;
      tgt_g_q     <= tgt_g_d;
      tgt_b_q     <= tgt_b_d;
      en_q        <= en_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
    end
  end

  assign led_r_out  = cur_r_q;
  assign led_g_out  = cur_g_q;
  assign led_b_out  = cur_b_q;
  assign enable_out = en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_rgb_spi_rx.sv
// Scoreboard bench for rgb_spi_rx: frames push expected outputs,
// a monitor pops and compares on every frame_done pulse.
module tb_rgb_spi_rx;

  localparam int FD = 4;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] r, g, b;
  logic       en, done;
  logic [31:0] outs;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  time last_rise = 0;

  rgb_spi_rx #(.FADE_DIV(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (sck),
    .spi_cs_n   (cs_n),
    .spi_mosi   (mosi),
    .led_r_out  (r),
    .led_g_out  (g),
    .led_b_out  (b),
    .enable_out (en),
    .frame_done (done)
  );

  always #5 clk = ~clk;

  assign outs = {7'd0, en, r, g, b};

  function automatic logic [31:0] pk(input logic e, input logic [7:0] rr,
                                     input logic [7:0] gg, input logic [7:0] bb);
    return {7'd0, e, rr, gg, bb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every frame_done must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected frame_done", 32'd1, 32'd0);
      end else begin
        chk("commit outputs", outs, exp_q.pop_front());
        chk("commit latency", 32'(($time - last_rise) <= 45), 32'd1);
      end
    end
  end

  task automatic send(input bq_t bs, input bit keep_cs = 1'b0);
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (4) @(posedge clk);
    foreach (bs[i]) begin
      for (int k = 7; k >= 0; k--) begin
        #1 mosi = bs[i][k];
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        last_rise = $time;
        repeat (4) @(posedge clk);
        #1 sck = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    if (!keep_cs) begin
      #1 cs_n = 1'b1;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic trace_fade();
    int n = 0;
    int rt[$];
    logic [7:0] rv[$], bv[$];
    int gch = 0;
    logic [7:0] pr, pg, pb;
    logic [23:0] rseq = '0;
    logic [15:0] bseq = '0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fade commit seen", 32'(done), 32'd1);
    pr = r; pg = g; pb = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (r != pr) begin rv.push_back(r); rt.push_back(c); end
      if (b != pb) bv.push_back(b);
      if (g != pg) gch++;
      pr = r; pg = g; pb = b;
    end
    foreach (rv[i]) rseq = {rseq[15:0], rv[i]};
    foreach (bv[i]) bseq = {bseq[7:0], bv[i]};
    chk("fade r count", 32'(rv.size()), 32'd3);
    chk("fade r sequence", 32'(rseq), 32'h414243);
    chk("fade r interval 1", 32'(rt.size() >= 2 ? rt[1] - rt[0] : -1), 32'd4);
    chk("fade r interval 2", 32'(rt.size() >= 3 ? rt[2] - rt[1] : -1), 32'd4);
    chk("fade b count", 32'(bv.size()), 32'd2);
    chk("fade b sequence", 32'(bseq), 32'hBFBE);
    chk("fade g changes", 32'(gch), 32'd0);
    chk("fade final", outs, pk(1'b0, 8'h43, 8'h80, 8'hBE));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t f;
    logic [7:0] base;

    #3 rst = 1'b0;
    #1;
    chk("reset outputs", outs, 32'd0);
    chk("reset frame_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // SET
    exp_q.push_back(pk(1'b0, 8'h40, 8'h80, 8'hC0));
    f = '{8'h01, 8'h40, 8'h80, 8'hC0};
    send(f);
    drain();

    // Aborted SET
    f = '{8'h01, 8'h11, 8'h22};
    send(f);
    repeat (10) @(posedge clk);
    chk("aborted frame hold", outs, pk(1'b0, 8'h40, 8'h80, 8'hC0));

    // FADE with step trace
    exp_q.push_back(pk(1'b0, 8'h40, 8'h80, 8'hC0));
    f = '{8'h02, 8'h43, 8'h80, 8'hBE};
    fork
      send(f);
      trace_fade();
    join
    drain();

    // SET during an active fade
    exp_q.push_back(pk(1'b0, 8'h43, 8'h80, 8'hBE));
    f = '{8'h02, 8'hFF, 8'hFF, 8'hFF};
    send(f);
    drain();
    chk("fade in progress", 32'(r > 8'h43), 32'd1);
    exp_q.push_back(pk(1'b0, 8'h00, 8'h00, 8'h00));
    f = '{8'h01, 8'h00, 8'h00, 8'h00};
    send(f);
    drain();
    repeat (20) @(negedge clk);
    chk("set cancels fade", outs, 32'd0);

    // SET commit swept across all prescaler phases
    for (int ph = 0; ph < 4; ph++) begin
      base = (ph == 0) ? 8'h00 : 8'h10;
      exp_q.push_back(pk(1'b0, base, base << 1, (ph == 0) ? 8'h00 : 8'h30));
      f = '{8'h02, 8'hFF, 8'hFF, 8'hFF};
      send(f);
      repeat (ph) @(posedge clk);
      exp_q.push_back(pk(1'b0, 8'h10, 8'h20, 8'h30));
      f = '{8'h01, 8'h10, 8'h20, 8'h30};
      send(f);
      drain();
      repeat (12) @(negedge clk);
      chk("set vs tick hold", outs, pk(1'b0, 8'h10, 8'h20, 8'h30));
    end

    // ENABLE
    exp_q.push_back(pk(1'b1, 8'h10, 8'h20, 8'h30));
    f = '{8'h03, 8'h01};
    send(f);
    drain();

    // Unknown command
    f = '{8'h7F, 8'hAA, 8'hBB, 8'hCC};
    send(f);
    repeat (10) @(posedge clk);
    chk("unknown cmd hold", outs, pk(1'b1, 8'h10, 8'h20, 8'h30));

    // SET followed by trailing bytes
    exp_q.push_back(pk(1'b1, 8'h05, 8'h06, 8'h07));
    f = '{8'h01, 8'h05, 8'h06, 8'h07, 8'h99, 8'h88};
    send(f);
    drain();
    chk("extra bytes ignored", outs, pk(1'b1, 8'h05, 8'h06, 8'h07));

    // Reset mid-fade
    exp_q.push_back(pk(1'b1, 8'h05, 8'h06, 8'h07));
    f = '{8'h02, 8'hF0, 8'hF0, 8'hF0};
    send(f);
    drain();
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset mid-fade", outs, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post reset no fade", outs, 32'd0);

    // Reset mid-frame
    f = '{8'h01, 8'h33};
    send(f, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("reset mid-frame", outs, 32'd0);
    cs_n = 1'b1;
    sck  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    exp_q.push_back(pk(1'b0, 8'h0A, 8'h0B, 8'h0C));
    f = '{8'h01, 8'h0A, 8'h0B, 8'h0C};
    send(f);
    drain();
    chk("final state", outs, pk(1'b0, 8'h0A, 8'h0B, 8'h0C));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_spi_rx.md
# rgb_spi_rx

SPI-slave command receiver that sits directly upstream of the per-channel RGB delta-sigma drivers. It decodes byte frames from the host MCU, then holds three 8-bit colour levels and an enable bit. The levels are either written immediately or faded toward a target at a programmable rate. Its outputs connect one-to-one to the driver's `enable`, `led_r_in`, `led_g_in` and `led_b_in`.

## Interface
- `FADE_DIV`, default 1024: clk cycles per fade step; legal range 1..65535.
- `clk  in  1`: system clock; must be at least 4× the SPI clock.
- `rst  in  1`: asynchronous, active-low reset.
- `spi_sck  in  1`: SPI clock, mode 0, asynchronous to `clk`.
- `spi_cs_n  in  1`: chip select, active-low, asynchronous.
- `spi_mosi  in  1`: serial data, MSB first, asynchronous.
- `led_r_out  out  8`: current red level.
- `led_g_out  out  8`: current green level.
- `led_b_out  out  8`: current blue level.
- `enable_out  out  1`: LED enable.
- `frame_done  out  1`: one-cycle pulse when a valid command commits.

## Operation
- **Input sync.** `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through a 2-FF synchroniser. A sck rising edge is detected when the synced value is 1 and the previous value was 0. On that edge the synced mosi is shifted in.
- **Frame.** A frame runs from cs_n falling to cs_n rising. Byte 0 is the command. Data bytes follow.
  - 0x01 SET: 3 data bytes R, G, B. Commits current and target together.
  - 0x02 FADE: 3 data bytes R, G, B. Commits target only.
  - 0x03 ENABLE: 1 data byte. `enable_out` takes bit 0.
  - Any other command: ignored, and the FSM moves to DISCARD.
- **States.**
  - IDLE: waits for synced cs_n low, then goes to CMD.
  - CMD: after 8 bits, goes to DATA (valid command) or DISCARD.
  - DATA: counts bytes (index 0..2, or 0 only for ENABLE). Shadow-registers each byte. On the last bit of the final byte it commits and goes to DISCARD.
  - DISCARD: ignores further bits.
  - From any state, synced cs_n high returns to IDLE and clears the bit counter, byte index and shadow registers.
- **Atomicity.** Outputs change only at commit. A frame aborted by cs_n before its final bit produces no change and no `frame_done`.
- **Fade.** A prescaler counts 0..FADE_DIV-1 and wraps; a tick fires on the count FADE_DIV-1. On each tick, each channel independently moves by 1 toward its target. Arithmetic is unsigned 8-bit with no overshoot; a channel stops when it equals its target. The prescaler free-runs and is never reset by commands.
- **Precedence.**
  - A SET commit in the same cycle as a tick: SET wins and the tick is dropped for that cycle.
  - A FADE commit during an active fade: the new target takes effect from the next tick.
  - A SET during a fade cancels the fade, because target equals current afterwards.

## Timing
- **Reset values:**
  - `led_*_out` = 0, target registers = 0, `enable_out` = 0, `frame_done` = 0.
  - FSM in IDLE, prescaler = 0, synchroniser flops = idle levels (sck 0, cs_n 1).
- **Commit latency.** Outputs update on the clk edge after the cycle in which the 8th sck rising edge of the final byte is detected. This is 3–4 clk after the raw sck edge; the uncertainty comes from the synchroniser.
- `frame_done` is high for exactly 1 clk, in the same cycle the committed outputs first appear.
- **Fade latency.** A channel changes on the clk edge after a tick.
- **Fade duration.** A full 0→255 fade takes 255 × FADE_DIV clk.
- **cs_n timing.** cs_n must stay low for at least 2 clk after the last sck rising edge, otherwise the final bit is lost.
- **Reset mid-frame or mid-fade.** Asynchronous reset returns everything to the reset values immediately.

## Structure
- Package `rgb_spi_pkg` holds:
  - command constants `CMD_SET`/`CMD_FADE`/`CMD_ENABLE`
  - the FSM state enum (IDLE, CMD, DATA, DISCARD)
  - per-command data-byte counts.
- Sub-module `spi_sync_edge` holds one 2-FF synchroniser plus rise/fall detect. It is instantiated for sck and cs_n; mosi uses the sync path only.
- The top level contains the FSM, shift register, shadow registers, fade engine and prescaler.

## Test plan
- **SET:** reset, then frame 01 40 80 C0 → `led_r/g/b_out` = 0x40/0x80/0xC0 within 4 clk of the last sck edge; `frame_done` pulses once.
- **Aborted frame:** frame 01 11 22 with cs_n raised after byte 2 → outputs unchanged at 0x40/0x80/0xC0; no `frame_done`.
- **FADE:** FADE_DIV=4, from 0x40/0x80/0xC0 send 02 43 80 BE → R steps 41, 42, 43 at 4-clk intervals; G holds 80; B steps BF, BE; all stop.
- **SET during fade:** mid-fade SET 01 00 00 00 → outputs 0 at commit and no further steps. A SET commit forced in the same cycle as a tick → SET value wins.
- **ENABLE and unknown:** 03 01 → `enable_out`=1. 7F AA BB CC → no change and no `frame_done`. Extra bytes after a completed SET are ignored.
- **Reset mid-operation:** assert `rst` low mid-fade and mid-frame → all outputs 0 immediately. A following valid frame works normally.
